// File: rtl/dcache_pkg.sv
// Shared types and address-field geometry for the direct-mapped data cache.
package dcache_pkg;

    localparam int ADDR_W     = 8;
    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int LINES      = 8;
    localparam int BLOCK_W    = 32;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    localparam int TAG_HI    = 7;
    localparam int TAG_LO    = 5;
    localparam int INDEX_HI  = 4;
    localparam int INDEX_LO  = 2;
    localparam int OFFSET_HI = 1;
    localparam int OFFSET_LO = 0;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

endpackage

// File: rtl/dcache.sv
// Direct-mapped write-back data cache: 8 lines x 4 bytes between the CPU byte port
// and block-wide data memory. Stalls the CPU only while a miss is being serviced.
module dcache
    import dcache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [7:0]            writedata,
    output logic [7:0]            readdata,
    output logic                  busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
);

    state_t              state;
    logic                seen_busy;
    logic [LINES-1:0]    valid;
    logic [LINES-1:0]    dirty;
    logic [TAG_W-1:0]    tag_array  [LINES];
    logic [BLOCK_W-1:0]  data_array [LINES];
    logic [7:0]          readdata_q;

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [4:0]          bit_pos;
    logic [BLOCK_W-1:0]  line;
    logic [7:0]          sel_byte;
    logic                req;
    logic                hit;
    logic                mem_done;
    logic                write_hit;
    logic                fill_done;

    assign tag      = address[TAG_HI:TAG_LO];
    assign index    = address[INDEX_HI:INDEX_LO];
    assign offset   = address[OFFSET_HI:OFFSET_LO];
    assign bit_pos  = {offset, 3'b000};
    assign line     = data_array[index];
    assign sel_byte = line[bit_pos +: 8];

    assign req       = read | write;
    assign hit       = valid[index] && (tag_array[index] == tag);
    // A transfer only finishes once memory has shown busy at least once in this state.
    assign mem_done  = seen_busy && !mem_busywait;
    assign write_hit = (state == IDLE) && write && hit;
    assign fill_done = (state == ALLOCATE) && mem_done;

    always_comb begin
        busywait      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        readdata      = readdata_q;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    busywait = !RESET;
                end else if (read && !write && hit) begin
                    readdata = sel_byte;
                end
            end
            WRITEBACK: begin
                busywait      = 1'b1;
                mem_write     = 1'b1;
                mem_address   = {tag_array[index], index};
                mem_writedata = line;
            end
            ALLOCATE: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = {tag, index};
            end
            default: begin
                busywait = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            seen_busy  <= 1'b0;
            valid      <= '0;
            dirty      <= '0;
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata;
            case (state)
                IDLE: begin
                    seen_busy <= 1'b0;
                    if (write_hit) begin
                        dirty[index] <= 1'b1;
                    end else if (req && !hit) begin
                        state <= dirty[index] ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (mem_done) begin
                        state     <= ALLOCATE;
                        seen_busy <= 1'b0;
                    end else if (mem_busywait) begin
                        seen_busy <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (mem_done) begin
                        state        <= IDLE;
                        seen_busy    <= 1'b0;
                        valid[index] <= 1'b1;
                        dirty[index] <= 1'b0;
                    end else if (mem_busywait) begin
                        seen_busy <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    seen_busy <= 1'b0;
                end
            endcase
        end
    end

    // Line storage carries no reset; valid bits alone qualify its contents.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            data_array[index] <= mem_readdata;
            tag_array[index]  <= tag;
        end else if (write_hit) begin
            data_array[index][bit_pos +: 8] <= writedata;
        end
    end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back data cache between the CPU's byte-wide load/store port and the block-wide data memory. It presents the CPU-side memory handshake (read/write strobes, 8-bit address, busywait stall) and acts as the initiator toward the data memory, stalling the CPU only on misses. It is instantiated between `cpu` and `data_memory` in the testbench and top level.

## Interface
- No parameters. Geometry is fixed: 8 lines × 4 bytes; address[7:5]=tag, [4:2]=index, [1:0]=byte offset.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `read` in 1: CPU load request.
- `write` in 1: CPU store request.
- `address` in 8: CPU byte address.
- `writedata` in 8: CPU store data.
- `readdata` out 8: CPU load data.
- `busywait` out 1: stall to the CPU.
- `mem_read` out 1: block read request to memory.
- `mem_write` out 1: block write-back request to memory.
- `mem_address` out 6: block address {tag, index}.
- `mem_writedata` out 32: victim block; byte 0 in [7:0].
- `mem_readdata` in 32: fetched block; byte 0 in [7:0].
- `mem_busywait` in 1: memory is still servicing the request.

## Operation
- Per line: valid bit, dirty bit, 3-bit tag, 32-bit data.
- hit = valid[index] && tag[index]==address[7:5]. Evaluated combinationally.
- If `read` and `write` are both high, the request is treated as a write.
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: `busywait`=0.
- IDLE, request, hit:
  - `busywait`=0.
  - Read: `readdata` is the selected byte, combinationally.
  - Write: the byte is written at the next rising edge and dirty[index] is set.
- IDLE, request, miss:
  - `busywait`=1 combinationally in the same cycle.
  - Next state is WRITEBACK if dirty[index], else ALLOCATE.
- WRITEBACK:
  - `mem_write`=1, `mem_address`={stored tag, index}, `mem_writedata`=line data.
  - Completes per the memory handshake, then goes to ALLOCATE.
- ALLOCATE:
  - `mem_read`=1, `mem_address`={address[7:5], index}.
  - On completion: line data ← `mem_readdata`, valid=1, dirty=0, tag updated; state → IDLE.
  - The request is then re-evaluated as a hit in IDLE.
- `busywait`=1 throughout WRITEBACK and ALLOCATE.
- Memory handshake:
  - The request is held constant until complete.
  - Complete = first rising edge sampling `mem_busywait`=0 after at least one earlier edge in the same state sampled it 1.
  - A per-state "seen busy" flag implements this and is cleared on state entry.
- When not hit/reading, `readdata` holds its last value; it is don't-care to the CPU.

## Timing
- Reset (asynchronous, immediate):
  - All outputs 0: `busywait`, `mem_read`, `mem_write`, `mem_address`, `mem_writedata`, `readdata`.
  - State → IDLE; all valid and dirty bits cleared.
  - Data and tag arrays need not be cleared.
- Hit: zero stall cycles. A read has data valid in the request cycle; a write commits at the ending edge.
- Clean miss: stall = memory latency + 1 cycle (IDLE→ALLOCATE edge), plus the hit cycle.
- Dirty miss: adds one full memory latency for the write-back.
- `mem_read` and `mem_write` are never high simultaneously. Both fall in the same cycle the state leaves.
- Reset mid-miss: memory strobes drop immediately and dirty data is discarded. The CPU must re-issue the request.
- A request removed during a stall is a protocol violation. The fetch still completes; no write occurs.

## Structure
- Shared package `dcache_pkg`: state enum (IDLE/WRITEBACK/ALLOCATE), field widths, and tag/index/offset slice constants.
- Single module, no sub-modules. A byte-select mux is inline.

## Test plan
- Reset: assert `RESET` mid-cycle → all outputs 0 immediately. Then read 0x01 → miss (`busywait`=1, `mem_read`=1, `mem_address`=0x00).
- Clean read miss then hit:
  - Memory returns 0x44332211 after 5 busy cycles.
  - Read 0x01 → `readdata`=0x22 once `busywait` falls.
  - Read 0x03 next → 0x44 with `busywait`=0 throughout.
- Write hit: write 0xAB to 0x02 → no stall; then read 0x02 → 0xAB; dirty[0]=1.
- Dirty conflict miss: after the write hit, read 0x21 →
  - `mem_write`=1, `mem_address`=0x00, `mem_writedata`=0x44AB2211.
  - Then `mem_read`=1, `mem_address`=0x08; readdata is byte 1 of the new block.
- Write miss on clean line: write 0x5A to 0x9C → allocate from `mem_address`=0x27, then the byte is written. A subsequent read of 0x9C returns 0x5A.
- Reset during WRITEBACK: `mem_write` drops asynchronously. Then read 0x02 → clean miss with no write-back.
